// File: rtl/mcc_phase_sequencer.sv
// mcc_phase_sequencer
//   Multi-pass controller for a shared SIZE-bit dynamic Manchester-carry-chain
//   adder. It accepts a WIDTH-bit operand pair, then feeds the adder one slice
//   per pass, LSB slice first. Each pass is PRE_CYCLES of precharge followed by
//   EVAL_CYCLES of evaluate. The slice carry is chained from one pass to the
//   next, and the WIDTH-bit sum is assembled and returned.
//
//   Ports
//     clk, rst_n                  clock, async active-low reset
//     in_valid/in_ready           request handshake (ready only in IDLE)
//     in_a, in_b, in_cin          WIDTH-bit operands and carry-in
//     add_a, add_b, add_cin       registered slice operands to the adder
//     add_clk                     per-bit phase vector (0 = precharge, 1 = evaluate)
//     add_sum, add_cout           adder result for the current slice
//     out_valid/out_ready         result handshake
//     out_sum, out_cout           assembled sum and final carry
//     busy                        high whenever not IDLE
module mcc_phase_sequencer #(
  parameter  int SIZE        = 16,
  parameter  int PASSES      = 4,
  parameter  int PRE_CYCLES  = 1,
  parameter  int EVAL_CYCLES = 2,
  localparam int WIDTH       = SIZE * PASSES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [SIZE-1:0]  add_a,
  output logic [SIZE-1:0]  add_b,
  output logic             add_cin,
  output logic [SIZE-1:0]  add_clk,
  input  logic [SIZE-1:0]  add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh, b_sh;   // operands, shifted down one slice per pass
  logic             carry;        // chained slice carry, drives add_cin directly
  logic             accept, capture, last;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    last    = (idx == IW'(PASSES - 1));
    case (state)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = PRE;
        cnt_d   = '0;
      end
      PRE: if (cnt == CW'(PRE_CYCLES - 1)) begin
        state_d = EVAL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      EVAL: if (cnt == CW'(EVAL_CYCLES - 1)) begin
        capture = 1'b1;
        cnt_d   = '0;
        state_d = last ? DONE : PRE;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      add_clk  <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      // Decoded from the next state so the phase vector is a clean flop output.
      add_clk <= {SIZE{state_d == EVAL}};
      if (accept) begin
        a_sh  <= in_a;
        b_sh  <= in_b;
        carry <= in_cin;
        idx   <= '0;
      end
      if (capture) begin
        out_sum[idx*SIZE +: SIZE] <= add_sum;
        if (last) begin
          out_cout <= add_cout;
        end else begin
          // Slice operands only move on an edge that enters PRE, so on the
          // last pass they are held through DONE.
          a_sh  <= a_sh >> SIZE;
          b_sh  <= b_sh >> SIZE;
          carry <= add_cout;
          idx   <= idx + IW'(1);
        end
      end
    end
  end

  assign add_a     = a_sh[SIZE-1:0];
  assign add_b     = b_sh[SIZE-1:0];
  assign add_cin   = carry;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule
